// File: rtl/mode_switch_controller_pkg.sv
// Shared mode, source and FSM encodings for the mode-change handshake.
// Every drawer and the top-level responder import this package.
package mode_switch_controller_pkg;

    localparam logic [1:0] MODE_RESERVED = 2'b00;
    localparam logic [1:0] MODE_WELCOME  = 2'b01;
    localparam logic [1:0] MODE_CALC     = 2'b10;
    localparam logic [1:0] MODE_GRAPH    = 2'b11;

    localparam int SRC_WELCOME = 0;
    localparam int SRC_CALC    = 1;
    localparam int SRC_GRAPH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // A request only moves the mode when it names a real, different mode.
    function automatic logic is_switch(
        input logic [1:0] tgt,
        input logic [1:0] cur
    );
        return (tgt != MODE_RESERVED) && (tgt != cur);
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mode_hold_timer.sv
// Loadable down-counter with zero flag; shared by the blank and
// button-release hold phases of the mode switch controller.
module mode_hold_timer #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mode_switch_controller.sv
// Top-level responder for drawer mode-change requests: owns the main
// mode, acks the active drawer, blanks video and waits for button release.
module mode_switch_controller
    import mode_switch_controller_pkg::*;
#(
    parameter int NUM_SRC        = 3,
    parameter int BLANK_CYCLES   = 420000,
    parameter int RELEASE_CYCLES = 250000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req_vec,
    input  logic [2*NUM_SRC-1:0]   target_vec,
    input  logic                   btn_center,
    output logic [NUM_SRC-1:0]     ack_vec,
    output logic [1:0]             current_main_mode,
    output logic                   mode_changed,
    output logic                   blank,
    output logic                   busy
);

    localparam int CW = cnt_width(BLANK_CYCLES, RELEASE_CYCLES);
    localparam logic [CW-1:0] BLANK_LD   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LD = CW'(RELEASE_CYCLES - 1);

    state_e               state_q;
    logic [1:0]           mode_q;
    logic [NUM_SRC-1:0]   ack_q;
    logic                 chg_q;
    logic                 blank_q;
    logic                 busy_q;

    logic                 act_req;
    logic [1:0]           act_tgt;
    logic [NUM_SRC-1:0]   act_sel;
    logic                 do_switch;

    logic                 tmr_load;
    logic [CW-1:0]        tmr_val;
    logic                 tmr_dec;
    logic                 tmr_zero;

    // Only the drawer that owns the current mode is listened to.
    always_comb begin
        act_req = 1'b0;
        act_tgt = MODE_RESERVED;
        act_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((i < 3) && (mode_q == 2'(i + 1))) begin
                act_req    = req_vec[i];
                act_tgt    = target_vec[2*i +: 2];
                act_sel[i] = 1'b1;
            end
        end
    end

    assign do_switch = is_switch(act_tgt, mode_q);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = RELEASE_LD;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (act_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = do_switch ? BLANK_LD : RELEASE_LD;
                end
            end
            ST_BLANK: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (btn_center) begin
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    mode_hold_timer #(
        .W       (CW),
        .RST_VAL (RELEASE_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASE;
            mode_q  <= MODE_WELCOME;
            ack_q   <= '0;
            chg_q   <= 1'b0;
            blank_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            ack_q <= '0;
            chg_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (act_req) begin
                        ack_q  <= act_sel;
                        busy_q <= 1'b1;
                        if (do_switch) begin
                            mode_q  <= act_tgt;
                            chg_q   <= 1'b1;
                            blank_q <= 1'b1;
                            state_q <= ST_BLANK;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end
                end
                ST_BLANK: begin
                    if (tmr_zero) begin
                        blank_q <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Requester must have dropped req so one request
                    // never earns a second ack.
                    if (!btn_center && tmr_zero && !act_req) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    blank_q <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST_RELEASE;
                end
            endcase
        end
    end

    assign ack_vec           = ack_q;
    assign current_main_mode = mode_q;
    assign mode_changed      = chg_q;
    assign blank             = blank_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_mode_switch_controller.sv
// Scoreboard bench for mode_switch_controller with short blank and
// release times so every phase can be counted cycle by cycle.
module tb_mode_switch_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req_vec = '0;
    logic [5:0] target_vec = '0;
    logic       btn_center = 1'b0;
    logic [2:0] ack_vec;
    logic [1:0] current_main_mode;
    logic       mode_changed;
    logic       blank;
    logic       busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] ack;
        logic [1:0] mode;
        logic       chg;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] exp_mode = 2'b01;

    always #5 clk = ~clk;

    mode_switch_controller #(
        .NUM_SRC        (3),
        .BLANK_CYCLES   (4),
        .RELEASE_CYCLES (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_vec           (req_vec),
        .target_vec        (target_vec),
        .btn_center        (btn_center),
        .ack_vec           (ack_vec),
        .current_main_mode (current_main_mode),
        .mode_changed      (mode_changed),
        .blank             (blank),
        .busy              (busy)
    );

    // Every ack or mode change must match the next queued expectation.
    always @(negedge clk) begin
        if (ack_vec !== 3'b000 || mode_changed !== 1'b0) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got ack=%b mode=%b chg=%b want none",
                         ack_vec, current_main_mode, mode_changed);
            end else begin
                e = sb_q.pop_front();
                if (ack_vec !== e.ack || current_main_mode !== e.mode ||
                    mode_changed !== e.chg) begin
                    failures++;
                    $display("FAIL sb_event got ack=%b mode=%b chg=%b want ack=%b mode=%b chg=%b",
                             ack_vec, current_main_mode, mode_changed,
                             e.ack, e.mode, e.chg);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] tgt);
        exp_t       e;
        logic [1:0] m;
        logic       sw;
        m  = exp_mode;
        sw = (tgt != 2'b00) && (tgt != m);
        e.ack  = 3'b001 << (int'(m) - 1);
        e.mode = sw ? tgt : m;
        e.chg  = sw;
        sb_q.push_back(e);
        exp_mode = e.mode;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout got busy=%b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (current_main_mode !== 2'b01 || ack_vec !== 3'b000 ||
            blank !== 1'b0 || mode_changed !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_async got mode=%b ack=%b blank=%b chg=%b busy=%b want 01 000 0 0 1",
                     current_main_mode, ack_vec, blank, mode_changed, busy);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy !== (k < 2) || current_main_mode !== 2'b01 ||
                blank !== 1'b0 || ack_vec !== 3'b000) begin
                failures++;
                $display("FAIL reset_release_c%0d got busy=%b mode=%b blank=%b ack=%b want busy=%b 01 0 000",
                         k, busy, current_main_mode, blank, ack_vec, (k < 2));
            end
        end
    endtask

    task automatic test_switch();
        int nb;
        req_vec    = 3'b001;
        target_vec = 6'b00_00_10;
        push_exp(2'b10);
        step();
        checks++;
        if (ack_vec !== 3'b001 || current_main_mode !== 2'b10 ||
            mode_changed !== 1'b1 || blank !== 1'b1) begin
            failures++;
            $display("FAIL switch_ack got ack=%b mode=%b chg=%b blank=%b want 001 10 1 1",
                     ack_vec, current_main_mode, mode_changed, blank);
        end
        req_vec = 3'b000;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (blank !== 1'b1) break;
            nb++;
            step();
            if (k == 0) begin
                checks++;
                if (ack_vec !== 3'b000 || mode_changed !== 1'b0) begin
                    failures++;
                    $display("FAIL switch_pulse_width got ack=%b chg=%b want 000 0",
                             ack_vec, mode_changed);
                end
            end
        end
        checks++;
        if (nb != 4) begin
            failures++;
            $display("FAIL switch_blank_len got %0d want 4", nb);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy !== (k < 2)) begin
                failures++;
                $display("FAIL switch_release_c%0d got busy=%b want %b",
                         k, busy, (k < 2));
            end
        end
    endtask

    task automatic test_btn_held();
        logic bad_busy;
        logic bad_ack;
        btn_center = 1'b1;
        req_vec    = 3'b010;
        target_vec = 6'b00_11_00;
        push_exp(2'b11);
        step();
        checks++;
        if (ack_vec !== 3'b010 || current_main_mode !== 2'b11) begin
            failures++;
            $display("FAIL btn_switch_ack got ack=%b mode=%b want 010 11",
                     ack_vec, current_main_mode);
        end
        req_vec  = 3'b000;
        bad_busy = 1'b0;
        bad_ack  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) begin
                req_vec    = 3'b100;
                target_vec = 6'b01_00_00;
            end
            step();
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (k > 0 && ack_vec !== 3'b000) bad_ack = 1'b1;
        end
        checks++;
        if (bad_busy || bad_ack) begin
            failures++;
            $display("FAIL btn_held got busy_drop=%b stray_ack=%b want 0 0",
                     bad_busy, bad_ack);
        end
        req_vec    = 3'b000;
        btn_center = 1'b0;
        step();
        step();
        btn_center = 1'b1;
        step();
        btn_center = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL btn_bounce_restart got busy=%b want 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL btn_release_done got busy=%b want 0", busy);
        end
        req_vec    = 3'b100;
        target_vec = 6'b01_00_00;
        push_exp(2'b01);
        step();
        checks++;
        if (ack_vec !== 3'b100 || current_main_mode !== 2'b01) begin
            failures++;
            $display("FAIL graph_to_welcome got ack=%b mode=%b want 100 01",
                     ack_vec, current_main_mode);
        end
        req_vec = 3'b000;
        wait_idle("graph_to_welcome");
    endtask

    task automatic test_inactive();
        req_vec    = 3'b010;
        target_vec = 6'b00_11_00;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ack_vec !== 3'b000 || current_main_mode !== 2'b01 ||
                busy !== 1'b0) begin
                failures++;
                $display("FAIL inactive_c%0d got ack=%b mode=%b busy=%b want 000 01 0",
                         k, ack_vec, current_main_mode, busy);
            end
        end
        req_vec = 3'b000;
    endtask

    task automatic test_null();
        logic [1:0] tg[2];
        logic       bad;
        tg[0] = 2'b01;
        tg[1] = 2'b00;
        for (int j = 0; j < 2; j++) begin
            req_vec    = 3'b001;
            target_vec = {4'b0000, tg[j]};
            push_exp(tg[j]);
            step();
            checks++;
            if (ack_vec !== 3'b001 || current_main_mode !== 2'b01 ||
                mode_changed !== 1'b0 || blank !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL null_%0d_ack got ack=%b mode=%b chg=%b blank=%b busy=%b want 001 01 0 0 1",
                         j, ack_vec, current_main_mode, mode_changed, blank, busy);
            end
            bad = 1'b0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (busy !== 1'b1 || ack_vec !== 3'b000) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL null_%0d_held got reentry=1 want 0", j);
            end
            req_vec = 3'b000;
            step();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL null_%0d_drop got busy=%b want 0", j, busy);
            end
        end
    endtask

    task automatic test_reset_mid_blank();
        logic bad;
        req_vec    = 3'b001;
        target_vec = 6'b00_00_11;
        push_exp(2'b11);
        step();
        checks++;
        if (ack_vec !== 3'b001 || current_main_mode !== 2'b11) begin
            failures++;
            $display("FAIL rstblank_ack got ack=%b mode=%b want 001 11",
                     ack_vec, current_main_mode);
        end
        req_vec = 3'b000;
        step();
        #2 rst_n = 1'b0;
        #1;
        exp_mode = 2'b01;
        checks++;
        if (blank !== 1'b0 || current_main_mode !== 2'b01 ||
            ack_vec !== 3'b000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstblank_async got blank=%b mode=%b ack=%b busy=%b want 0 01 000 1",
                     blank, current_main_mode, ack_vec, busy);
        end
        step();
        rst_n      = 1'b1;
        req_vec    = 3'b001;
        target_vec = 6'b00_00_10;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ack_vec !== 3'b000 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rstblank_hold got early_ack_or_idle=1 want 0");
        end
        req_vec = 3'b000;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rstblank_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int         src;
        logic [1:0] tgt;
        logic [2:0] sel;
        logic [2:0] others;
        logic [5:0] tv;
        for (int it = 0; it < 8; it++) begin
            src    = int'(exp_mode) - 1;
            tgt    = 2'($urandom_range(0, 3));
            sel    = 3'b001 << src;
            others = 3'($urandom_range(0, 7));
            tv     = 6'($urandom);
            tv[2*src +: 2] = tgt;
            req_vec    = sel | others;
            target_vec = tv;
            push_exp(tgt);
            step();
            checks++;
            if (ack_vec !== sel || current_main_mode !== exp_mode) begin
                failures++;
                $display("FAIL b2b_%0d got ack=%b mode=%b want %b %b",
                         it, ack_vec, current_main_mode, sel, exp_mode);
            end
            req_vec = 3'b000;
            wait_idle("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_btn_held();
        test_inactive();
        test_null();
        test_reset_mid_blank();
        test_back_to_back();
        step();
        step();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_pending got %0d want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
